// File: rtl/hanoi_pkg.sv
// rtl/hanoi_pkg.sv - shared types and helpers for the Tower-of-Hanoi engine
package hanoi_pkg;

  localparam int MAX_DISKS = 16;

  typedef enum logic [2:0] {
    E_NONE   = 3'd0,
    E_SAME   = 3'd1,
    E_RANGE  = 3'd2,
    E_EMPTY  = 3'd3,
    E_ORDER  = 3'd4,
    E_LOCKED = 3'd5
  } err_code_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } low_bit_t;

  // Index of the smallest disk on a peg; valid=0 when the peg is empty.
  function automatic low_bit_t lowest_set(input logic [MAX_DISKS-1:0] mask);
    low_bit_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = MAX_DISKS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hanoi_if.sv
// rtl/hanoi_if.sv - move-request handshake bundle
interface hanoi_if #(
  parameter int PW = 2
) ();
  logic          mv_valid;
  logic          mv_ready;
  logic [PW-1:0] fr;
  logic [PW-1:0] to;

  modport master (output mv_valid, output fr, output to, input mv_ready);
  modport slave  (input mv_valid, input fr, input to, output mv_ready);
endinterface

// File: rtl/hanoi_move_check.sv
// rtl/hanoi_move_check.sv - combinational legality check for one move
module hanoi_move_check
  import hanoi_pkg::*;
#(
  parameter int N_DISKS = 4,
  parameter int N_PEGS  = 3,
  parameter int PW      = 2
) (
  input  logic [N_DISKS-1:0] pegs_i [N_PEGS],
  input  logic [PW-1:0]      fr_i,
  input  logic [PW-1:0]      to_i,
  input  logic               solved_i,
  output logic               legal_o,
  output err_code_e          err_code_o,
  output logic [N_DISKS-1:0] move_bit_o
);

  logic               fr_in, to_in;
  logic [N_DISKS-1:0] src, dst;
  low_bit_t           top_src, top_dst;

  // Evaluate the error checks in priority order; out-of-range pegs read as empty.
  always_comb begin
    fr_in      = 32'(fr_i) < N_PEGS;
    to_in      = 32'(to_i) < N_PEGS;
    src        = fr_in ? pegs_i[fr_i] : '0;
    dst        = to_in ? pegs_i[to_i] : '0;
    top_src    = lowest_set(16'(src));
    top_dst    = lowest_set(16'(dst));
    move_bit_o = src & ~(src - N_DISKS'(1));
    if (solved_i)
      err_code_o = E_LOCKED;
    else if (!fr_in || !to_in)
      err_code_o = E_RANGE;
    else if (fr_i == to_i)
      err_code_o = E_SAME;
    else if (!top_src.valid)
      err_code_o = E_EMPTY;
    else if (top_dst.valid && (top_dst.idx < top_src.idx))
      err_code_o = E_ORDER;
    else
      err_code_o = E_NONE;
    legal_o = (err_code_o == E_NONE);
  end

endmodule

// File: rtl/hanoi_param.sv
// rtl/hanoi_param.sv - parametrised Tower-of-Hanoi state engine
module hanoi_param
  import hanoi_pkg::*;
#(
  parameter int N_DISKS = 4,
  parameter int N_PEGS  = 3,
  parameter int TARGET  = N_PEGS - 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  hanoi_if.slave                    mv,
  output logic [N_PEGS*N_DISKS-1:0] peg_o,
  output logic                      mv_ok,
  output logic                      mv_err,
  output logic [2:0]                err_code,
  output logic                      solved,
  output logic [CNT_W-1:0]          move_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int PW = (N_PEGS > 2) ? $clog2(N_PEGS) : 1;

  state_e             state_q;
  logic [N_DISKS-1:0] pegs_q [N_PEGS];
  logic [N_DISKS-1:0] pegs_d [N_PEGS];
  logic [PW-1:0]      fr_q, to_q;
  logic               ok_q, err_q, solved_q, solved_d;
  err_code_e          code_q;
  logic [CNT_W-1:0]   move_cnt_q, err_cnt_q;

  logic               legal;
  err_code_e          chk_code;
  logic [N_DISKS-1:0] move_bit;

  hanoi_move_check #(
    .N_DISKS (N_DISKS),
    .N_PEGS  (N_PEGS),
    .PW      (PW)
  ) u_check (
    .pegs_i     (pegs_q),
    .fr_i       (fr_q),
    .to_i       (to_q),
    .solved_i   (solved_q),
    .legal_o    (legal),
    .err_code_o (chk_code),
    .move_bit_o (move_bit)
  );

  // Peg masks after committing the latched move (only used when it is legal).
  always_comb begin
    pegs_d = pegs_q;
    for (int p = 0; p < N_PEGS; p++) begin
      if (32'(fr_q) == p) pegs_d[p] = pegs_d[p] & ~move_bit;
      if (32'(to_q) == p) pegs_d[p] = pegs_d[p] | move_bit;
    end
    solved_d = (pegs_d[TARGET] == {N_DISKS{1'b1}});
  end

  // Two-state request FSM: latch in IDLE, evaluate and respond in CHECK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      for (int p = 0; p < N_PEGS; p++) pegs_q[p] <= (p == 0) ? '1 : '0;
      fr_q       <= '0;
      to_q       <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= E_NONE;
      solved_q   <= 1'b0;
      move_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (clr) begin
      state_q    <= IDLE;
      for (int p = 0; p < N_PEGS; p++) pegs_q[p] <= (p == 0) ? '1 : '0;
      fr_q       <= '0;
      to_q       <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= E_NONE;
      solved_q   <= 1'b0;
      move_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ok_q  <= 1'b0;
          err_q <= 1'b0;
          if (mv.mv_valid) begin
            fr_q    <= mv.fr;
            to_q    <= mv.to;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if (legal) begin
            pegs_q   <= pegs_d;
            solved_q <= solved_d;
            ok_q     <= 1'b1;
            if (move_cnt_q != {CNT_W{1'b1}}) move_cnt_q <= move_cnt_q + 1'b1;
          end else begin
            err_q  <= 1'b1;
            code_q <= chk_code;
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < N_PEGS; p++) begin : g_peg
    assign peg_o[p*N_DISKS +: N_DISKS] = pegs_q[p];
  end

  assign mv.mv_ready = (state_q == IDLE);
  assign mv_ok       = ok_q;
  assign mv_err      = err_q;
  assign err_code    = code_q;
  assign solved      = solved_q;
  assign move_cnt    = move_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_hanoi_param.sv
// tb/tb_hanoi_param.sv - directed self-checking bench for hanoi_param
module tb_hanoi_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hanoi_if #(.PW(2)) if_a ();
  hanoi_if #(.PW(2)) if_b ();
  hanoi_if #(.PW(2)) if_c ();

  logic [11:0] peg_a, peg_b;
  logic [3:0]  peg_c;
  logic        ok_a, err_a, solved_a, ok_b, err_b, solved_b, ok_c, err_c, solved_c;
  logic [2:0]  code_a, code_b, code_c;
  logic [15:0] mc_a, ec_a, mc_c, ec_c;
  logic [1:0]  mc_b, ec_b;

  hanoi_param dut_a (
    .clk(clk), .rst(rst), .clr(clr), .mv(if_a), .peg_o(peg_a), .mv_ok(ok_a), .mv_err(err_a),
    .err_code(code_a), .solved(solved_a), .move_cnt(mc_a), .err_cnt(ec_a)
  );

  hanoi_param #(.N_DISKS(4), .N_PEGS(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .mv(if_b), .peg_o(peg_b), .mv_ok(ok_b), .mv_err(err_b),
    .err_code(code_b), .solved(solved_b), .move_cnt(mc_b), .err_cnt(ec_b)
  );

  hanoi_param #(.N_DISKS(1), .N_PEGS(4)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .mv(if_c), .peg_o(peg_c), .mv_ok(ok_c), .mv_err(err_c),
    .err_code(code_c), .solved(solved_c), .move_cnt(mc_c), .err_cnt(ec_c)
  );

  // Present one request to DUT d, then return #1 after the response edge.
  task automatic send(input int d, input logic [1:0] f, input logic [1:0] t);
    @(negedge clk);
    case (d)
      0: begin if_a.mv_valid = 1'b1; if_a.fr = f; if_a.to = t; end
      1: begin if_b.mv_valid = 1'b1; if_b.fr = f; if_b.to = t; end
      default: begin if_c.mv_valid = 1'b1; if_c.fr = f; if_c.to = t; end
    endcase
    @(posedge clk); #1;
    if_a.mv_valid = 1'b0;
    if_b.mv_valid = 1'b0;
    if_c.mv_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (peg_a !== 12'h00F) begin n_fail++; $display("FAIL reset_peg: got %h exp %h", peg_a, 12'h00F); end
    n_tests++; if ({if_a.mv_ready, ok_a, err_a, solved_a} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got %b exp 1000", {if_a.mv_ready, ok_a, err_a, solved_a}); end
    n_tests++; if ({mc_a, ec_a, 1'b0, code_a} !== 36'h0) begin n_fail++; $display("FAIL reset_counters: got %h exp 0", {mc_a, ec_a, 1'b0, code_a}); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_legal();
    send(0, 2'd0, 2'd1);
    n_tests++; if ({ok_a, err_a} !== 2'b10) begin n_fail++; $display("FAIL legal_pulse: got %b exp 10", {ok_a, err_a}); end
    n_tests++; if (peg_a !== 12'h01E) begin n_fail++; $display("FAIL legal_peg: got %h exp %h", peg_a, 12'h01E); end
    n_tests++; if (mc_a !== 16'd1) begin n_fail++; $display("FAIL legal_cnt: got %0d exp 1", mc_a); end
    @(posedge clk); #1;
    n_tests++; if ({ok_a, err_a} !== 2'b00) begin n_fail++; $display("FAIL legal_fall: got %b exp 00", {ok_a, err_a}); end
    send(0, 2'd0, 2'd1);
    n_tests++; if ({ok_a, err_a, code_a} !== 5'b01_100) begin n_fail++; $display("FAIL order_err: got %b exp 01100", {ok_a, err_a, code_a}); end
    n_tests++; if (peg_a !== 12'h01E || ec_a !== 16'd1 || mc_a !== 16'd1) begin n_fail++; $display("FAIL order_state: got peg %h ec %0d mc %0d exp 01e 1 1", peg_a, ec_a, mc_a); end
  endtask

  task automatic test_errors();
    do_clr();
    send(0, 2'd1, 2'd1);
    n_tests++; if ({err_a, code_a} !== 4'b1_001) begin n_fail++; $display("FAIL same_err: got %b exp 1001", {err_a, code_a}); end
    send(0, 2'd2, 2'd0);
    n_tests++; if ({err_a, code_a} !== 4'b1_011) begin n_fail++; $display("FAIL empty_err: got %b exp 1011", {err_a, code_a}); end
    send(0, 2'd3, 2'd0);
    n_tests++; if ({err_a, code_a} !== 4'b1_010) begin n_fail++; $display("FAIL range_err: got %b exp 1010", {err_a, code_a}); end
    n_tests++; if (ec_a !== 16'd3 || mc_a !== 16'd0 || peg_a !== 12'h00F) begin n_fail++; $display("FAIL err_counts: got ec %0d mc %0d peg %h exp 3 0 00f", ec_a, mc_a, peg_a); end
    send(0, 2'd0, 2'd2);
    n_tests++; if ({ok_a, code_a, mc_a} !== {1'b1, 3'd2, 16'd1}) begin n_fail++; $display("FAIL code_hold: got ok %b code %0d mc %0d exp 1 2 1", ok_a, code_a, mc_a); end
  endtask

  task automatic test_back_to_back();
    int mv_fr [15] = '{0, 0, 1, 0, 2, 2, 0, 0, 1, 1, 2, 1, 0, 0, 1};
    int mv_to [15] = '{1, 2, 2, 1, 0, 1, 1, 2, 2, 0, 0, 2, 1, 2, 2};
    do_clr();
    @(negedge clk);
    if_a.mv_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if_a.fr = 2'(mv_fr[i]);
      if_a.to = 2'(mv_to[i]);
      @(posedge clk); #1;
      n_tests++; if ({if_a.mv_ready, ok_a, err_a} !== 3'b000) begin n_fail++; $display("FAIL b2b_check_%0d: got %b exp 000", i, {if_a.mv_ready, ok_a, err_a}); end
      @(posedge clk); #1;
      n_tests++; if ({if_a.mv_ready, ok_a, err_a} !== 3'b110) begin n_fail++; $display("FAIL b2b_resp_%0d: got %b exp 110", i, {if_a.mv_ready, ok_a, err_a}); end
      if (i == 13) begin
        n_tests++; if (solved_a !== 1'b0) begin n_fail++; $display("FAIL b2b_early_solved: got %b exp 0", solved_a); end
      end
    end
    if_a.mv_valid = 1'b0;
    n_tests++; if (mc_a !== 16'd15 || solved_a !== 1'b1 || peg_a !== 12'hF00 || ec_a !== 16'd0) begin n_fail++; $display("FAIL b2b_final: got mc %0d solved %b peg %h ec %0d exp 15 1 f00 0", mc_a, solved_a, peg_a, ec_a); end
    send(0, 2'd2, 2'd1);
    n_tests++; if ({ok_a, err_a, code_a} !== 5'b01_101 || ec_a !== 16'd1 || peg_a !== 12'hF00) begin n_fail++; $display("FAIL lock_err: got %b ec %0d peg %h exp 01101 1 f00", {ok_a, err_a, code_a}, ec_a, peg_a); end
    do_clr();
    n_tests++; if (peg_a !== 12'h00F || {solved_a, code_a} !== 4'h0 || mc_a !== 16'd0 || ec_a !== 16'd0 || if_a.mv_ready !== 1'b1) begin n_fail++; $display("FAIL clr_restore: got peg %h solved %b code %0d mc %0d ec %0d", peg_a, solved_a, code_a, mc_a, ec_a); end
  endtask

  task automatic test_rst_mid();
    send(0, 2'd0, 2'd2);
    n_tests++; if (peg_a !== 12'h10E) begin n_fail++; $display("FAIL pre_rst_peg: got %h exp 10e", peg_a); end
    @(negedge clk); if_a.mv_valid = 1'b1; if_a.fr = 2'd2; if_a.to = 2'd1;
    @(posedge clk); #1; if_a.mv_valid = 1'b0;
    n_tests++; if (if_a.mv_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_check: got %b exp 0", if_a.mv_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (peg_a !== 12'h00F || {ok_a, err_a} !== 2'b00 || mc_a !== 16'd0 || if_a.mv_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_async: got peg %h ok/err %b mc %0d rdy %b", peg_a, {ok_a, err_a}, mc_a, if_a.mv_ready); end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({ok_a, err_a} !== 2'b00 || peg_a !== 12'h00F) begin n_fail++; $display("FAIL rst_mid_no_resp: got ok/err %b peg %h exp 00 00f", {ok_a, err_a}, peg_a); end
  endtask

  task automatic test_clr_mid();
    send(0, 2'd0, 2'd1);
    @(negedge clk); if_a.mv_valid = 1'b1; if_a.fr = 2'd0; if_a.to = 2'd2;
    @(posedge clk); #1; if_a.mv_valid = 1'b0; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    n_tests++; if ({ok_a, err_a} !== 2'b00 || peg_a !== 12'h00F || mc_a !== 16'd0 || if_a.mv_ready !== 1'b1) begin n_fail++; $display("FAIL clr_mid: got ok/err %b peg %h mc %0d rdy %b", {ok_a, err_a}, peg_a, mc_a, if_a.mv_ready); end
    @(posedge clk); #1;
    n_tests++; if ({ok_a, err_a} !== 2'b00) begin n_fail++; $display("FAIL clr_mid_late: got %b exp 00", {ok_a, err_a}); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 6; i++) begin
      send(1, 2'd0, 2'd0);
      if (i == 1) begin
        n_tests++; if (ec_b !== 2'd2) begin n_fail++; $display("FAIL sat_two: got %0d exp 2", ec_b); end
      end
      if (i == 3) begin
        n_tests++; if (ec_b !== 2'd3) begin n_fail++; $display("FAIL sat_four: got %0d exp 3", ec_b); end
      end
    end
    n_tests++; if (ec_b !== 2'd3 || {err_b, code_b} !== 4'b1_001 || mc_b !== 2'd0) begin n_fail++; $display("FAIL sat_six: got ec %0d err/code %b mc %0d exp 3 1001 0", ec_b, {err_b, code_b}, mc_b); end
  endtask

  task automatic test_small();
    n_tests++; if (peg_c !== 4'b0001 || solved_c !== 1'b0) begin n_fail++; $display("FAIL small_reset: got peg %b solved %b exp 0001 0", peg_c, solved_c); end
    send(2, 2'd0, 2'd3);
    n_tests++; if (ok_c !== 1'b1 || solved_c !== 1'b1 || peg_c !== 4'b1000 || mc_c !== 16'd1) begin n_fail++; $display("FAIL small_move: got ok %b solved %b peg %b mc %0d exp 1 1 1000 1", ok_c, solved_c, peg_c, mc_c); end
    send(2, 2'd3, 2'd0);
    n_tests++; if ({err_c, code_c} !== 4'b1_101 || peg_c !== 4'b1000) begin n_fail++; $display("FAIL small_lock: got %b peg %b exp 1101 1000", {err_c, code_c}, peg_c); end
  endtask

  initial begin
    if_a.mv_valid = 1'b0; if_a.fr = '0; if_a.to = '0;
    if_b.mv_valid = 1'b0; if_b.fr = '0; if_b.to = '0;
    if_c.mv_valid = 1'b0; if_c.fr = '0; if_c.to = '0;
    test_reset();
    test_legal();
    test_errors();
    test_back_to_back();
    test_rst_mid();
    test_clr_mid();
    test_saturate();
    test_small();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
